// File: rtl/bus_pkg.sv
// Shared bus-subsystem types and the round-robin pick helper.
// Used by the serial word arbiter and its beat counter.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_0,
        GRANT_1
    } arb_state_e;

    typedef logic src_id_t;

    // prio names the source that wins when both request.
    function automatic arb_state_e rr_pick(
        input logic    valid_0,
        input logic    valid_1,
        input src_id_t prio
    );
        arb_state_e pick;
        if (valid_0 && valid_1) begin
            pick = prio ? GRANT_1 : GRANT_0;
        end else if (valid_0) begin
            pick = GRANT_0;
        end else if (valid_1) begin
            pick = GRANT_1;
        end else begin
            pick = IDLE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/word_beat_counter.sv
// Modulo-WORD_LEN beat counter; last flags the final bit of a word.
// clr takes precedence over inc.
module word_beat_counter
    import bus_pkg::*;
#(
    parameter int WORD_LEN = 8,
    parameter int CNT_W    = $clog2(WORD_LEN)
) (
    input  logic clk,
    input  logic aresetn,
    input  logic inc,
    input  logic clr,
    output logic last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_LEN - 1);

    logic [CNT_W-1:0] cnt;

    assign last = (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_word_arbiter.sv
// Two-master round-robin arbiter for a shared bit-serial link.
// Grants last exactly one word; bits pass through combinationally.
module serial_word_arbiter
    import bus_pkg::*;
#(
    parameter int WORD_LEN = 8,
    parameter int CNT_W    = $clog2(WORD_LEN)
) (
    input  logic clk,
    input  logic aresetn,
    input  logic s_valid_0,
    output logic s_ready_0,
    input  logic s_data_0,
    input  logic s_valid_1,
    output logic s_ready_1,
    input  logic s_data_1,
    output logic m_valid,
    input  logic m_ready,
    output logic m_data,
    output logic m_id,
    output logic m_last
);

    arb_state_e state, state_nxt;
    src_id_t    prio, prio_nxt;
    logic       beat;
    logic       last;

    word_beat_counter #(
        .WORD_LEN (WORD_LEN),
        .CNT_W    (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .aresetn (aresetn),
        .inc     (beat),
        .clr     (beat && last),
        .last    (last)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            prio  <= 1'b0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        m_valid   = 1'b0;
        m_data    = 1'b0;
        m_id      = 1'b0;
        m_last    = 1'b0;
        s_ready_0 = 1'b0;
        s_ready_1 = 1'b0;
        beat      = 1'b0;
        unique case (state)
            IDLE: begin
                state_nxt = rr_pick(s_valid_0, s_valid_1, prio);
            end
            GRANT_0: begin
                m_valid   = s_valid_0;
                m_data    = s_data_0;
                m_last    = last;
                s_ready_0 = m_ready;
                beat      = s_valid_0 && m_ready;
                // The other source wins ties at word end.
                if (beat && last) begin
                    prio_nxt  = 1'b1;
                    state_nxt = rr_pick(s_valid_0, s_valid_1, 1'b1);
                end
            end
            GRANT_1: begin
                m_valid   = s_valid_1;
                m_data    = s_data_1;
                m_id      = 1'b1;
                m_last    = last;
                s_ready_1 = m_ready;
                beat      = s_valid_1 && m_ready;
                if (beat && last) begin
                    prio_nxt  = 1'b0;
                    state_nxt = rr_pick(s_valid_0, s_valid_1, 1'b0);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_word_arbiter.sv
// Directed and random checks of serial_word_arbiter against a
// word-level ownership model, WORD_LEN=4.
module tb_serial_word_arbiter;

    localparam int WL = 4;

    logic clk = 1'b0;
    logic aresetn;
    logic s_valid_0, s_data_0, s_ready_0;
    logic s_valid_1, s_data_1, s_ready_1;
    logic m_valid, m_ready, m_data, m_id, m_last;

    int total = 0;
    int bad   = 0;

    // Model: owner -1 means nobody holds the link.
    int owner = -1;
    int done  = 0;
    int mprio = 0;

    logic obs_bits[$];
    logic obs_ids[$];

    serial_word_arbiter #(.WORD_LEN(WL)) dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .s_valid_0 (s_valid_0),
        .s_ready_0 (s_ready_0),
        .s_data_0  (s_data_0),
        .s_valid_1 (s_valid_1),
        .s_ready_1 (s_ready_1),
        .s_data_1  (s_data_1),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_id      (m_id),
        .m_last    (m_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic ev, ed, ei, el, er0, er1, vo;
        ev = 0; ed = 0; ei = 0; el = 0; er0 = 0; er1 = 0;
        if (aresetn && owner >= 0) begin
            vo  = (owner == 0) ? s_valid_0 : s_valid_1;
            ev  = vo;
            ed  = (owner == 0) ? s_data_0 : s_data_1;
            ei  = (owner == 1);
            el  = (done == WL - 1);
            er0 = (owner == 0) && m_ready;
            er1 = (owner == 1) && m_ready;
        end
        chk("m_valid", m_valid, ev);
        chk("m_data", m_data, ed);
        chk("m_id", m_id, ei);
        chk("m_last", m_last, el);
        chk("s_ready_0", s_ready_0, er0);
        chk("s_ready_1", s_ready_1, er1);
        if (m_valid && m_ready) begin
            obs_bits.push_back(m_data);
            if (m_last) obs_ids.push_back(m_id);
        end
    endtask

    task automatic model_edge();
        logic vo, vx;
        if (!aresetn) begin
            owner = -1; done = 0; mprio = 0;
        end else if (owner < 0) begin
            if (s_valid_0 && s_valid_1) owner = mprio;
            else if (s_valid_0) owner = 0;
            else if (s_valid_1) owner = 1;
        end else begin
            vo = (owner == 0) ? s_valid_0 : s_valid_1;
            vx = (owner == 0) ? s_valid_1 : s_valid_0;
            if (vo && m_ready) begin
                done++;
                if (done == WL) begin
                    done  = 0;
                    mprio = 1 - owner;
                    if (vx) owner = 1 - owner;
                end
            end
        end
    endtask

    task automatic step(input logic v0, input logic d0,
                        input logic v1, input logic d1,
                        input logic mr);
        s_valid_0 = v0; s_data_0 = d0;
        s_valid_1 = v1; s_data_1 = d1;
        m_ready   = mr;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        step(0, 0, 0, 0, 1);
        step(1, 1, 1, 1, 1);
        aresetn = 1'b1;
    endtask

    initial begin
        logic exp_bits[4];
        logic exp_ids[4];
        exp_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
        exp_ids  = '{1'b0, 1'b1, 1'b0, 1'b1};
        s_valid_0 = 0; s_data_0 = 0;
        s_valid_1 = 0; s_data_1 = 0;
        m_ready = 1;
        aresetn = 1'b0;
        #1;
        do_reset();

        // Single source, then lone re-request of a second word.
        step(1, 0, 0, 0, 1);
        obs_bits.delete();
        for (int i = 0; i < 4; i++) step(1, exp_bits[i], 0, 0, 1);
        chk("single_len", obs_bits.size() == 4, 1'b1);
        for (int i = 0; i < 4; i++)
            if (i < obs_bits.size()) chk("single_bit", obs_bits[i], exp_bits[i]);
        for (int i = 0; i < 4; i++) step(1, 1'(i), 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Contention from reset.
        do_reset();
        obs_ids.delete();
        step(1, 1, 1, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 1'(i), 1, 1'(~i), 1);
        chk("cont_words", obs_ids.size() == 4, 1'b1);
        for (int i = 0; i < 4; i++)
            if (i < obs_ids.size()) chk("cont_id", obs_ids[i], exp_ids[i]);

        // Backpressure mid-word.
        do_reset();
        step(1, 0, 0, 0, 1);
        obs_bits.delete();
        for (int i = 0; i < 8; i++)
            step(1, (i % 2 == 0) ? exp_bits[i / 2] : 1'b0, 0, 0, 1'(i % 2 == 0));
        chk("bp_len", obs_bits.size() == 4, 1'b1);
        for (int i = 0; i < 4; i++)
            if (i < obs_bits.size()) chk("bp_bit", obs_bits[i], exp_bits[i]);

        // Stall of master 0 while master 1 waits.
        do_reset();
        step(1, 0, 1, 0, 1);
        step(1, 1, 1, 0, 1);
        step(1, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1);
        step(1, 1, 1, 0, 1);
        step(1, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1'(i), 1);

        // Reset during beat 2 of an id-1 word.
        do_reset();
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 1, 1);
        s_data_1 = 1'b1;
        #2;
        aresetn = 1'b0;
        #1;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 1'b0);
        chk("rst_m_id", m_id, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_s_ready_1", s_ready_1, 1'b0);
        step(1, 1, 1, 1, 1);
        aresetn = 1'b1;
        step(1, 1, 1, 1, 1);
        step(1, 1, 1, 1, 1);
        chk("rst_first_id", m_id, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom),
                 1'($urandom_range(0, 4) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
